// File: rtl/sequence_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: one-hot state encoding
// and the parity build switch (SEQUENCE_TX_PARITY_EN).
package sequence_tx_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE = 4'b0001;
  localparam logic [ST_W-1:0] ST_SEND = 4'b0010;
  localparam logic [ST_W-1:0] ST_GAP  = 4'b0100;
  localparam logic [ST_W-1:0] ST_DONE = 4'b1000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND,
    S_GAP  = ST_GAP,
    S_DONE = ST_DONE
  } state_t;

`ifdef SEQUENCE_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/sequence_tx_shifter.sv
// Pattern load/shift register with a captured copy for reloading between repetitions,
// a bit counter and a last-bit flag. Parity output exists only with SEQUENCE_TX_PARITY_EN.
module sequence_tx_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  output logic             nxt_bit,
  output logic             cap_msb,
`ifdef SEQUENCE_TX_PARITY_EN
  output logic             parity,
`endif
  output logic             last
);
  import sequence_tx_pkg::*;

  localparam int CW = $clog2(PAT_W);

  logic [PAT_W-1:0] sr;
  logic [PAT_W-1:0] cap;
  logic [CW-1:0]    cnt;

  // sr[PAT_W-1] is the bit currently on the line; cnt is its index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cap <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= pattern;
      cap <= pattern;
      cnt <= '0;
    end else if (reload) begin
      sr  <= cap;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[PAT_W-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end
  end

  assign nxt_bit = sr[PAT_W-2];
  assign cap_msb = cap[PAT_W-1];
  assign last    = (cnt == CW'(PAT_W-1));
`ifdef SEQUENCE_TX_PARITY_EN
  assign parity  = PARITY_EN & (^cap);
`endif

endmodule

// File: rtl/sequence_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with optional
// idle gaps. Optional trailing even-parity bit per repetition via SEQUENCE_TX_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs 0
// SEND  | one pattern (or parity) bit per cycle
// GAP   | idle cycles between repetitions, busy held
// DONE  | one-cycle done pulse; a new start is accepted here
module sequence_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             data,
  output logic             data_vld,
  output logic             busy,
  output logic             done
);
  import sequence_tx_pkg::*;

  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [GW-1:0]    gap_cnt;
  logic             nxt_bit, cap_msb, last;
  logic             accept, rep_end, more, shift, reload;

`ifdef SEQUENCE_TX_PARITY_EN
  logic parity, par_ph;
  assign rep_end = (state == S_SEND) && par_ph;
`else
  assign rep_end = (state == S_SEND) && last;
`endif

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign more   = (rem > CNT_W'(1));
  assign shift  = (state == S_SEND) && !last;
  assign reload = rep_end && more;

  sequence_tx_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .reload  (reload),
    .shift   (shift),
    .pattern (pattern),
    .nxt_bit (nxt_bit),
    .cap_msb (cap_msb),
`ifdef SEQUENCE_TX_PARITY_EN
    .parity  (parity),
`endif
    .last    (last)
  );

  // outputs are computed for the cycle following each edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      gap_cnt  <= '0;
      data     <= 1'b0;
      data_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SEQUENCE_TX_PARITY_EN
      par_ph   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_SEND;
            rem      <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            data     <= pattern[PAT_W-1];
            data_vld <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state    <= S_IDLE;
            data     <= 1'b0;
            data_vld <= 1'b0;
            busy     <= 1'b0;
          end
        end
        S_SEND: begin
          if (rep_end) begin
`ifdef SEQUENCE_TX_PARITY_EN
            par_ph <= 1'b0;
`endif
            if (more) begin
              rem <= rem - CNT_W'(1);
              if (GAP > 0) begin
                state    <= S_GAP;
                gap_cnt  <= GW'(GAP_M1);
                data     <= 1'b0;
                data_vld <= 1'b0;
              end else begin
                data     <= cap_msb;
                data_vld <= 1'b1;
              end
            end else begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              data     <= 1'b0;
              data_vld <= 1'b0;
            end
`ifdef SEQUENCE_TX_PARITY_EN
          end else if (last) begin
            par_ph   <= 1'b1;
            data     <= parity;
            data_vld <= 1'b1;
`endif
          end else begin
            data     <= nxt_bit;
            data_vld <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state    <= S_SEND;
            data     <= cap_msb;
            data_vld <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          data     <= 1'b0;
          data_vld <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_tx.sv
// Directed bench for sequence_tx: two instances (GAP=0 and GAP=2), table-driven streams
// plus hand sequences for reset abort and restart in the DONE cycle.
module tb_sequence_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       s0 = 1'b0, s2 = 1'b0;
  logic [3:0] p0 = '0, p2 = '0, r0 = '0, r2 = '0;
  logic       data0, vld0, busy0, done0;
  logic       data2, vld2, busy2, done2;

  sequence_tx #(.PAT_W(4), .CNT_W(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .start(s0), .pattern(p0), .repeat_n(r0),
    .data(data0), .data_vld(vld0), .busy(busy0), .done(done0)
  );

  sequence_tx #(.PAT_W(4), .CNT_W(4), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .start(s2), .pattern(p2), .repeat_n(r2),
    .data(data2), .data_vld(vld2), .busy(busy2), .done(done2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit            sel2;
    logic [3:0]    pat;
    logic [3:0]    rep;
    bit [8*16-1:0] exp;   // '1'/'0' valid bit, '_' idle gap cycle
    int            len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs(input bit sel2);
    return sel2 ? {data2, vld2, busy2, done2} : {data0, vld0, busy0, done0};
  endfunction

  // checks len cycles starting at the current negedge, then the done cycle
  task automatic stream(input bit sel2, input bit [8*16-1:0] exp, input int len, input string tag);
    logic [3:0] o;
    logic [7:0] c;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      c = exp[8*(len-1-i) +: 8];
      o = outs(sel2);
      chk($sformatf("%s vld[%0d]", tag, i), o[2], c != 8'h5F);
      chk($sformatf("%s data[%0d]", tag, i), o[3], c == 8'h31);
      chk($sformatf("%s busy[%0d]", tag, i), o[1], 1'b1);
      chk($sformatf("%s done[%0d]", tag, i), o[0], 1'b0);
    end
    @(negedge clk);
    o = outs(sel2);
    chk($sformatf("%s done pulse", tag), o[0], 1'b1);
    chk($sformatf("%s busy in done", tag), o[1], 1'b0);
    chk($sformatf("%s vld in done", tag), o[2], 1'b0);
    chk($sformatf("%s data in done", tag), o[3], 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] o;
    @(negedge clk);
    if (v.sel2) begin s2 = 1'b1; p2 = v.pat; r2 = v.rep; end
    else        begin s0 = 1'b1; p0 = v.pat; r0 = v.rep; end
    @(negedge clk);
    s0 = 1'b0; s2 = 1'b0;
    stream(v.sel2, v.exp, v.len, $sformatf("vec%0d", idx));
    @(negedge clk);
    o = outs(v.sel2);
    chk($sformatf("vec%0d done cleared", idx), o[0], 1'b0);
    chk($sformatf("vec%0d idle busy", idx), o[1], 1'b0);
    chk($sformatf("vec%0d idle vld", idx), o[2], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SEQUENCE_TX_PARITY_EN
    vecs[0] = '{1'b0, 4'b1011, 4'd1, "10111", 5};
    vecs[1] = '{1'b0, 4'b1011, 4'd3, "101111011110111", 15};
    vecs[2] = '{1'b1, 4'b1100, 4'd2, "11000__11000", 12};
    vecs[3] = '{1'b1, 4'b1100, 4'd0, "11000", 5};
    vecs[4] = '{1'b0, 4'b1011, 4'd2, "1011110111", 10};
    vecs[5] = '{1'b1, 4'b0001, 4'd2, "00011__00011", 12};
`else
    vecs[0] = '{1'b0, 4'b1011, 4'd1, "1011", 4};
    vecs[1] = '{1'b0, 4'b1011, 4'd3, "101110111011", 12};
    vecs[2] = '{1'b1, 4'b1100, 4'd2, "1100__1100", 10};
    vecs[3] = '{1'b1, 4'b1100, 4'd0, "1100", 4};
    vecs[4] = '{1'b0, 4'b0110, 4'd2, "01100110", 8};
    vecs[5] = '{1'b1, 4'b0001, 4'd2, "0001__0001", 10};
`endif

    // reset state
    #12;
    chk("reset data0", data0, 1'b0);
    chk("reset vld0", vld0, 1'b0);
    chk("reset busy0", busy0, 1'b0);
    chk("reset done0", done0, 1'b0);
    chk("reset busy2", busy2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start held high, pattern changed while busy, restart accepted in DONE cycle
    @(negedge clk);
    s0 = 1'b1; p0 = 4'b1011; r0 = 4'd1;
    @(negedge clk);
    p0 = 4'b0110;
`ifdef SEQUENCE_TX_PARITY_EN
    stream(1'b0, "10111", 5, "hold1");
    @(negedge clk);
    s0 = 1'b0;
    stream(1'b0, "01100", 5, "hold2");
`else
    stream(1'b0, "1011", 4, "hold1");
    @(negedge clk);
    s0 = 1'b0;
    stream(1'b0, "0110", 4, "hold2");
`endif
    @(negedge clk);
    chk("hold no restart busy", busy0, 1'b0);
    chk("hold done cleared", done0, 1'b0);

    // reset mid-SEND on the second bit
    @(negedge clk);
    s0 = 1'b1; p0 = 4'b1011; r0 = 4'd3;
    @(negedge clk);
    s0 = 1'b0;
    chk("abort bit0 data", data0, 1'b1);
    chk("abort bit0 vld", vld0, 1'b1);
    @(negedge clk);
    chk("abort bit1 data", data0, 1'b0);
    chk("abort bit1 vld", vld0, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("abort async vld", vld0, 1'b0);
    chk("abort async busy", busy0, 1'b0);
    chk("abort async data", data0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("abort in reset done", done0, 1'b0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after reset done", done0, 1'b0);
      chk("after reset busy", busy0, 1'b0);
      chk("after reset vld", vld0, 1'b0);
    end
    run_vec(vecs[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_tx.md
Name: sequence_tx

Overview:
Serial pattern transmitter, the generating end of the team's serial bit-sequence detectors.
- On a start request, captures a PAT_W-bit pattern and a repeat count.
- Shifts the pattern out MSB-first, one bit per clk, repeating it with optional idle gaps.
- Drives detector stimulus and serial test streams.
- All outputs registered.

Parameters:
PAT_W, 4, pattern length in bits (≥2)
CNT_W, 4, width of repeat-count input
GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request transmission; sampled only when busy=0
pattern  input  PAT_W  pattern to send, bit PAT_W-1 first; captured on accepted start
repeat_n  input  CNT_W  number of repetitions; 0 treated as 1; captured on accepted start
data  output  1  serial bit; 0 whenever data_vld=0
data_vld  output  1  data carries a pattern (or parity) bit this cycle
busy  output  1  transmission in progress; start ignored
done  output  1  one-cycle pulse after final bit of final repetition

Behaviour:
- Reset (rst=0, immediate/async): data=0, data_vld=0, busy=0, done=0, state=IDLE, all counters and shift register cleared. Reset mid-transmission aborts with no done pulse.
- States (one-hot): IDLE, SEND, GAP, DONE.
- IDLE: outputs 0. start=1 at edge k:
  - capture pattern into the shift register and max(repeat_n,1) into the remaining-rep counter;
  - go to SEND.
  - Cycle k+1: busy=1, data_vld=1, data=pattern[PAT_W-1].
- SEND: one bit per cycle, MSB first; bit counter counts 0..PAT_W-1 (width $clog2(PAT_W)).
  - On last bit with reps remaining >1: decrement, reload captured pattern. Go to GAP if GAP>0, else stay in SEND; the next rep's MSB follows in the very next cycle.
  - On last bit of final rep: go to DONE.
- GAP: exactly GAP cycles with data=0, data_vld=0, busy=1, then SEND.
- DONE: one cycle with done=1, busy=0, data_vld=0, then IDLE. start asserted during the DONE cycle is accepted (busy=0); next cycle is first bit of the new transmission. done still pulses once.
- start, pattern and repeat_n changes while busy=1 are ignored.
- Total busy cycles = R·L + (R−1)·GAP, where R = max(repeat_n,1) and L = PAT_W (or PAT_W+1 with parity). done follows in the next cycle.
- Illegal state encoding: recover to IDLE with outputs 0.

Optional Feature:
SEQUENCE_TX_PARITY_EN
- Defined: each repetition is followed by one extra bit, the even parity (XOR) of the captured pattern, with data_vld=1. L = PAT_W+1.
- Undefined: no parity bit; parity logic is absent. L = PAT_W.

Decomposition:
- Package sequence_tx_pkg: one-hot state localparams (IDLE/SEND/GAP/DONE), state width constant, parity enable helper constant.
- One natural sub-module: sequence_tx_shifter, a PAT_W-bit load/shift register with bit counter and last-bit flag.
- FSM, gap counter and repeat counter stay in top.

Test Plan:
- Reset mid-SEND (PAT_W=4, pattern=4'b1011, repeat_n=3, drop rst on 2nd bit) -> outputs 0 immediately, no done, IDLE after release.
- pattern=4'b1011, repeat_n=1, GAP=0 -> data_vld 4 cycles starting cycle after start, data 1,0,1,1. done the cycle after last bit; busy high exactly 4 cycles.
- pattern=4'b1011, repeat_n=3, GAP=0 -> 12 contiguous valid bits 101110111011, done at cycle 13 after start. Looped into the 1011 overlapping detector, the detector flags 3 times.
- pattern=4'b1100, repeat_n=2, GAP=2 -> 1,1,0,0, two cycles data_vld=0/data=0, 1,1,0,0, done; repeat_n=0 behaves as 1.
- start held high throughout with a pattern change mid-transmission -> changes ignored while busy. Restart accepted in the DONE cycle; the new first bit follows done directly.
- With SEQUENCE_TX_PARITY_EN: pattern=4'b1011, repeat_n=2 -> 1,0,1,1,1,1,0,1,1,1 (parity 1 after each rep), done after 10 bits.
